// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared defaults, arbitration encodings and clog2 helper
package mem_ctrl_pkg;
  localparam int DEF_NPORTS = 4;
  localparam int DEF_NBANKS = 4;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int ARB_RR     = 0;
  localparam int ARB_FIXED  = 1;
  // never returns 0 so single-entry selectors still get a 1-bit index
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: per-bank arbiter, round-robin from a pointer or fixed lowest-index priority
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int NPORTS   = DEF_NPORTS,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] req,
  output logic [NPORTS-1:0] gnt
);
  localparam int PW = clog2(NPORTS);
  logic [PW-1:0] ptr, nxt;
  logic          hit;
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    nxt = ptr;
    for (int i = 0; i < NPORTS; i++) begin
      int j;
      j = (ARB_MODE == ARB_FIXED) ? i : (int'(ptr) + i) % NPORTS;
      if (!hit && req[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        nxt    = PW'((j + 1) % NPORTS);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (hit && ARB_MODE == ARB_RR) ptr <= nxt;
  end
endmodule

// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl: multi-port controller over NBANKS independent single-access banks
module banked_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int NPORTS   = DEF_NPORTS,
  parameter int NBANKS   = DEF_NBANKS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] wdata,
  output logic [NPORTS-1:0]        gnt,
  output logic [NPORTS-1:0]        rvalid,
  output logic [NPORTS*DATA_W-1:0] rdata
);
  localparam int BW    = clog2(NBANKS);
  localparam int OW    = ADDR_W - BW;
  localparam int DEPTH = 1 << OW;
  logic [BW-1:0]     bk   [NPORTS];
  logic [OW-1:0]     off  [NPORTS];
  logic [NPORTS-1:0] breq [NBANKS];
  logic [NPORTS-1:0] bgnt [NBANKS];
  logic [NPORTS-1:0] rv_q;
  logic [DATA_W-1:0] mem  [NBANKS][DEPTH];
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      bk[p]  = addr[p*ADDR_W+OW +: BW];
      off[p] = addr[p*ADDR_W +: OW];
    end
  end
  always_comb begin
    for (int b = 0; b < NBANKS; b++)
      for (int p = 0; p < NPORTS; p++)
        breq[b][p] = req[p] && !reset && bk[p] == BW'(b);
  end
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    rr_arbiter #(.NPORTS(NPORTS), .ARB_MODE(ARB_MODE)) u_arb (
      .clk  (clk),
      .reset(reset),
      .req  (breq[b]),
      .gnt  (bgnt[b])
    );
  end
  // banks partition the ports, so the per-bank grants never overlap
  always_comb begin
    gnt = '0;
    for (int b = 0; b < NBANKS; b++) gnt = gnt | bgnt[b];
  end
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++)
      if (gnt[p] && we[p]) mem[bk[p]][off[p]] <= wdata[p*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rv_q  <= '0;
      rdata <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        rv_q[p] <= gnt[p] && !we[p];
        if (gnt[p] && !we[p]) rdata[p*DATA_W +: DATA_W] <= mem[bk[p]][off[p]];
      end
    end
  end
  // a read granted just before reset must not surface while reset is high
  assign rvalid = rv_q & {NPORTS{!reset}};
endmodule

// File: tb/tb_banked_mem_ctrl.sv
// tb_banked_mem_ctrl: directed and random scoreboard bench against a queue/array reference model
module tb_banked_mem_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = '0, we = '0;
  logic [47:0]  addr = '0;
  logic [127:0] wdata = '0;
  logic [3:0]   gnt, rvalid, gnt1, rvalid1;
  logic [127:0] rdata, rdata1;
  always #5 clk = ~clk;

  banked_mem_ctrl #(.ARB_MODE(0)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
  );
  banked_mem_ctrl #(.ARB_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1)
  );

  typedef struct { logic [31:0] d; bit dc; int due; } exp_t;
  exp_t        exq [4][$];
  logic [31:0] mm [int];
  logic [31:0] held [4];
  int ptr [4];
  int cyc = 0;
  int compared = 0, mismatched = 0;
  logic [3:0]   last_exp, last_gnt, last_gnt1, last_rv;
  logic [127:0] last_rd;

  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] ex);
    compared++;
    if (act !== ex) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, ex, cyc);
    end
  endtask

  function automatic int bank_of(input int a);
    return (a >> 10) & 3;
  endfunction

  // monitor: retires expected reads as rvalid appears
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (reset) begin
        chk("rvalid_in_reset", rvalid[p], 1'b0);
        exq[p].delete();
        held[p] = '0;
      end else if (rvalid[p]) begin
        if (exq[p].size() == 0) chk("spurious_rvalid", 1'b1, 1'b0);
        else begin
          exp_t e;
          e = exq[p].pop_front();
          chk("rvalid_latency", 128'(cyc), 128'(e.due));
          if (!e.dc) chk("rdata", rdata[p*DW +: DW], e.d);
        end
        held[p] = rdata[p*DW +: DW];
      end else begin
        chk("rdata_hold", rdata[p*DW +: DW], held[p]);
        if (exq[p].size() != 0 && exq[p][0].due <= cyc) begin
          chk("missing_rvalid", 1'b0, 1'b1);
          void'(exq[p].pop_front());
        end
      end
    end
  end

  task automatic setp(input int p, input bit r, input bit w, input int a, input logic [31:0] d);
    req[p] = r;
    we[p]  = w;
    addr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
  endtask

  task automatic release_granted();
    for (int p = 0; p < 4; p++) if (last_exp[p]) req[p] = 1'b0;
  endtask

  // one cycle: sample after the monitor, predict grants from the rules, update model
  task automatic tick();
    logic [3:0] e, ef;
    int win, fp, a, q;
    @(negedge clk);
    #1;
    last_rv = rvalid;
    last_rd = rdata;
    e = '0;
    ef = '0;
    if (reset) begin
      for (int b = 0; b < 4; b++) ptr[b] = 0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        win = -1;
        fp = -1;
        for (int i = 0; i < 4; i++) begin
          q = (ptr[b] + i) % 4;
          if (win < 0 && req[q] && bank_of(int'(addr[q*AW +: AW])) == b) win = q;
          if (fp < 0 && req[i] && bank_of(int'(addr[i*AW +: AW])) == b) fp = i;
        end
        if (fp >= 0) ef[fp] = 1'b1;
        if (win >= 0) begin
          e[win] = 1'b1;
          ptr[b] = (win + 1) % 4;
          a = int'(addr[win*AW +: AW]);
          if (we[win]) mm[a] = wdata[win*DW +: DW];
          else begin
            exp_t x;
            x.dc  = !mm.exists(a);
            x.d   = x.dc ? 32'h0 : mm[a];
            x.due = cyc + 1;
            exq[win].push_back(x);
          end
        end
      end
    end
    chk("gnt_rr", gnt, e);
    chk("gnt_fixed", gnt1, ef);
    last_exp  = e;
    last_gnt  = gnt;
    last_gnt1 = gnt1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < 4; p++) setp(p, 1'b1, 1'b0, p * 1024, '0);
    tick();
    chk("rst_rvalid", last_rv, 4'b0);
    chk("rst_rdata", rdata, 128'h0);
    chk("rst_rvalid_after_edge", rvalid, 4'b0);
    tick();
    chk("rst_gnt", last_gnt, 4'b0);
    reset = 1'b0;
    req = '0;

    setp(0, 1, 1, 257, 32'hAAAA_AAAA);
    setp(1, 1, 1, 50, 32'hBBBB_BBBB);
    tick();
    chk("conflict_first", last_gnt, 4'b0001);
    release_granted();
    tick();
    chk("conflict_second", last_gnt, 4'b0010);
    release_granted();
    setp(2, 1, 0, 257, '0);
    tick();
    release_granted();
    setp(3, 1, 0, 50, '0);
    tick();
    release_granted();
    chk("read_257", last_rd[2*DW +: DW], 32'hAAAA_AAAA);
    tick();
    chk("read_50", last_rd[3*DW +: DW], 32'hBBBB_BBBB);

    setp(1, 1, 1, 1048, 32'h1048_0001);
    setp(2, 1, 1, 2048, 32'h2048_0002);
    setp(3, 1, 1, 4015, 32'h4015_0003);
    tick();
    chk("par_write_gnt", last_gnt, 4'b1110);
    release_granted();
    setp(0, 1, 0, 257, '0);
    setp(1, 1, 0, 1048, '0);
    setp(2, 1, 0, 2048, '0);
    setp(3, 1, 0, 4015, '0);
    tick();
    chk("par_read_gnt", last_gnt, 4'b1111);
    release_granted();
    tick();
    chk("par_rvalid", last_rv, 4'b1111);
    chk("par_rdata", last_rd, {32'h4015_0003, 32'h2048_0002, 32'h1048_0001, 32'hAAAA_AAAA});

    do_reset();
    setp(0, 1, 0, 257, '0);
    setp(1, 1, 0, 50, '0);
    setp(2, 1, 0, 257, '0);
    setp(3, 1, 0, 50, '0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_sequence", last_gnt, 4'b0001 << (i % 4));
      chk("fixed_sequence", last_gnt1, 4'b0001);
    end
    req = '0;
    tick();

    setp(0, 1, 1, 15, 32'h1111_1111);
    tick();
    release_granted();
    setp(1, 1, 0, 15, '0);
    tick();
    chk("w2r_read_gnt", last_gnt, 4'b0010);
    release_granted();
    tick();
    chk("w2r_rvalid", last_rv, 4'b0010);
    chk("w2r_rdata", last_rd[1*DW +: DW], 32'h1111_1111);

    do_reset();
    setp(2, 1, 0, 257, '0);
    tick();
    chk("mid_read_gnt", last_gnt, 4'b0100);
    release_granted();
    reset = 1'b1;
    tick();
    chk("mid_rvalid_suppressed", last_rv, 4'b0);
    reset = 1'b0;
    setp(0, 1, 0, 257, '0);
    setp(1, 1, 0, 50, '0);
    setp(2, 1, 0, 257, '0);
    setp(3, 1, 0, 50, '0);
    tick();
    chk("mid_next_gnt", last_gnt, 4'b0001);
    chk("mid_rvalid_after", last_rv, 4'b0);
    req = '0;
    tick();

    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < 4; p++)
        if (!req[p] || last_exp[p]) begin
          if ($urandom_range(3) != 0)
            setp(p, 1, 1'($urandom_range(1)),
                 int'($urandom_range(3)) * 1024 + 5 + int'($urandom_range(2)), $urandom);
          else req[p] = 1'b0;
        end
      reset = ($urandom_range(49) == 0);
      tick();
    end
    reset = 1'b0;
    req = '0;
    tick();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/banked_mem_ctrl.md
BANKED_MEM_CTRL -- requirements
Module: banked_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the clock port named clk and the reset port named reset.
REQ-002 Parameter NPORTS, default 4, SHALL set the number of requester ports.
REQ-003 Parameter NBANKS, default 4 (power of two, 2..16), SHALL set the number of memory banks.
REQ-004 Parameter ADDR_W, default 12, SHALL set the word address width.
REQ-005 Parameter DATA_W, default 32, SHALL set the data width.
REQ-006 Parameter ARB_MODE, default 0, SHALL select the arbitration policy: 0 = round-robin, 1 = fixed priority with the lowest port index winning.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 req  in  NPORTS  per-port access request.
REQ-010 we  in  NPORTS  per-port write strobe; 1 = write, 0 = read; valid only while req is high.
REQ-011 addr  in  NPORTS*ADDR_W  flattened per-port word addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-012 wdata  in  NPORTS*DATA_W  flattened per-port write data.
REQ-013 gnt  out  NPORTS  combinational same-cycle grant; the access is performed at the clock edge on which gnt is high.
REQ-014 rvalid  out  NPORTS  registered read-data-valid.
REQ-015 rdata  out  NPORTS*DATA_W  registered read data, qualified by rvalid.

Function
REQ-016 Bank index SHALL be addr[ADDR_W-1 -: log2(NBANKS)]; the remaining low bits SHALL form the in-bank offset; each bank SHALL hold 2^ADDR_W/NBANKS words.
REQ-017 Each bank SHALL perform at most one access per cycle; requests to different banks SHALL be granted in the same cycle with no interaction between them.
REQ-018 Per bank, gnt[p] SHALL be 1 only if req[p] is 1, port p targets that bank, and port p wins that bank's arbitration.
REQ-019 In round-robin mode, each bank SHALL hold a pointer; the search SHALL start at the pointer and wrap from NPORTS-1 to 0, and after a grant to port w the pointer SHALL become (w+1) mod NPORTS; the pointer SHALL be unchanged when the bank grants nothing.
REQ-020 In round-robin mode, a port that requests continuously SHALL be granted within NPORTS cycles.
REQ-021 In fixed-priority mode, the bank pointer SHALL be unused and the lowest requesting index SHALL win.
REQ-022 A granted write SHALL update the bank at the grant edge; a granted read SHALL drive rdata and assert rvalid for exactly one cycle, in the cycle after the grant (latency 1).
REQ-023 A read granted in the cycle after a write to the same address SHALL return the newly written data.
REQ-024 An ungranted request SHALL produce no side effects; requesters SHALL hold req/we/addr/wdata stable until granted, and the block SHALL NOT buffer requests.
REQ-025 rdata for a port SHALL hold its last value while rvalid for that port is 0.

Reset
REQ-026 When reset is 1 at a clock edge, the block SHALL clear rvalid and rdata to 0, set all round-robin pointers to 0, and perform no memory write in that cycle.
REQ-027 gnt SHALL be forced to 0 while reset is 1; memory contents SHALL NOT be reset.
REQ-028 A read granted in the cycle before reset asserts SHALL NOT produce rvalid.

Structure
REQ-029 Shared package mem_ctrl_pkg SHALL hold the parameter defaults, the ARB_MODE encodings and a clog2 helper function.
REQ-030 Per-bank arbitration SHALL be a sub-module rr_arbiter (parameters NPORTS, ARB_MODE), instantiated NBANKS times; bank storage SHALL be inferred inside banked_mem_ctrl.

Verification
REQ-031 Reset: hold reset for 2 cycles with all req high -> gnt=0 throughout, rvalid=0, rdata=0 after the first edge.
REQ-032 Bank conflict: port0 writes AAAA_AAAA to 257 and port1 writes BBBB_BBBB to 50 in the same cycle (both bank 0) -> gnt=0001 in the first cycle, 0010 in the next; subsequent reads of 257 and 50 return AAAA_AAAA and BBBB_BBBB.
REQ-033 Parallel banks: ports 0-3 read 257, 1048, 2048 and 4015 in one cycle -> gnt=1111, and rvalid=1111 exactly one cycle later with the stored data.
REQ-034 Round-robin fairness: all four ports read bank 0 continuously for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; ARB_MODE=1 under the same stimulus -> port 0 granted every cycle.
REQ-035 Write-to-read: write 1111_1111 to 15, then read 15 on the next cycle from another port -> rdata=1111_1111 with rvalid one cycle after the read grant.
REQ-036 Mid-operation reset: assert reset in the cycle after a read grant -> rvalid stays 0 and the next round-robin grant goes to port 0.
